// File: rtl/square_iter_if.sv
// square_iter_if -- handshake bundle between a requester and square_iter.
//   init   : start request (requester -> squarer)
//   op_a   : unsigned operand, WIDTH bits (requester -> squarer)
//   result : square of the captured operand, 2*WIDTH bits (squarer -> requester)
//   done   : result valid and being presented (squarer -> requester)
//   busy   : an operation is in progress (squarer -> requester)
interface square_iter_if #(
  parameter int WIDTH = 16
);
  logic                 init;
  logic [WIDTH-1:0]     op_a;
  logic [2*WIDTH-1:0]   result;
  logic                 done;
  logic                 busy;

  modport master (
    output init,
    output op_a,
    input  result,
    input  done,
    input  busy
  );

  modport slave (
    input  init,
    input  op_a,
    output result,
    output done,
    output busy
  );
endinterface

// File: rtl/square_iter.sv
// square_iter -- iterative shift-and-add squarer.
// The operand is captured once on the START edge where init is high, then
// squared one multiplier bit per CHECK/ADD/SHIFT/CHECK_Z pass. The result is
// presented with done held high for DONE_HOLD cycles before returning idle.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : square_iter_if slave (init, op_a in; result, done, busy out)
module square_iter #(
  parameter int WIDTH     = 16,
  parameter int DONE_HOLD = 10
) (
  input  logic          clk,
  input  logic          rst,
  square_iter_if.slave  bus
);

  localparam int HW = (DONE_HOLD < 2) ? 1 : $clog2(DONE_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

  typedef enum logic [2:0] {
    START   = 3'd0,
    CHECK   = 3'd1,
    ADD     = 3'd2,
    SHIFT   = 3'd3,
    CHECK_Z = 3'd4,
    END1    = 3'd5
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]     mplr_reg;
  logic [2*WIDTH-1:0]   pp_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic [HW-1:0]        hold_reg;

  // Next-state logic; outputs are decoded from the state register alone.
  always_comb begin
    state_next = START;
    case (state_reg)
      START:   state_next = bus.init ? CHECK : START;
      CHECK:   state_next = mplr_reg[0] ? ADD : SHIFT;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = CHECK_Z;
      CHECK_Z: state_next = (mplr_reg == '0) ? END1 : CHECK;
      END1:    state_next = (hold_reg == HOLD_LAST) ? START : END1;
      default: state_next = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= START;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath. mplr is tested in CHECK_Z after the shift, so the loop ends as
  // soon as the remaining multiplier bits are all zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg  <= '0;
      mplr_reg   <= '0;
      pp_reg     <= '0;
      result_reg <= '0;
      hold_reg   <= '0;
    end else begin
      case (state_reg)
        START: begin
          if (bus.init) begin
            mcand_reg <= {{WIDTH{1'b0}}, bus.op_a};
            mplr_reg  <= bus.op_a;
            pp_reg    <= '0;
            hold_reg  <= '0;
          end
        end
        ADD: begin
          pp_reg <= pp_reg + mcand_reg;
        end
        SHIFT: begin
          mcand_reg <= mcand_reg << 1;
          mplr_reg  <= mplr_reg >> 1;
        end
        CHECK_Z: begin
          if (mplr_reg == '0) begin
            result_reg <= pp_reg;
          end
        end
        END1: begin
          hold_reg <= hold_reg + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.done   = (state_reg == END1);
  assign bus.busy   = (state_reg != START);

endmodule
